fp_addsub_pipe: RTL and testbench



---
 rtl/fp_addsub_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Pipelined minifloat adder/subtractor: align, add, normalize/round, then a
// result register. Denormals flush to zero; saturates instead of producing Inf.
module fp_addsub_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [3:0]           out_flags
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int ALN_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int LZ_W  = $clog2(SUM_W);
  localparam int E_W   = EXP_W + LZ_W + 2;
  localparam int DMAX  = MAN_W + 3;
  localparam logic signed [E_W-1:0] EMAX = E_W'(2**EXP_W - 1);

  if (EXP_W < 3 || MAN_W < 2 || BIAS < 1 || BIAS >= 2**EXP_W - 1) begin : g_bad_param
    $error("fp_addsub_pipe: unsupported EXP_W/MAN_W/BIAS");
  end

  function automatic logic [MAN_W+1:0] rne(input logic [ALN_W-1:0] n);
    logic up;
    up = n[2] & (n[1] | n[0] | n[3]);
    return {1'b0, n[ALN_W-1:3]} + {{(MAN_W+1){1'b0}}, up};
  endfunction

  function automatic logic [W-1:0] sat_max(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
  endfunction

  function automatic logic [LZ_W-1:0] lzc(input logic [ALN_W-1:0] v);
    logic [LZ_W-1:0] c;
    c = LZ_W'(ALN_W);
    for (int i = 0; i < ALN_W; i++)
      if (v[i]) c = LZ_W'(ALN_W - 1 - i);
    return c;
  endfunction

  logic stall;
  logic out_valid_q;
  logic [W-1:0] out_result_q;
  logic [3:0] out_flags_q;

  assign stall      = ~ena | (out_valid_q & ~out_ready);
  assign in_ready   = ~stall;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

  // ---- stage 1: swap, hidden bit, alignment shift with sticky
  logic             a_s, b_s, a_z, b_z, swap, l_s, s_s;
  logic [EXP_W-1:0] a_e, b_e, l_e, s_e, diff;
  logic [MAN_W-1:0] a_m, b_m, l_m, s_m;
  logic [2*MAN_W+5:0] s_wide;
  logic             sgn_p1_d, sub_p1_d, byp_p1_d, bypz_p1_d;
  logic [ALN_W-1:0] lsig_p1_d, ssig_p1_d;
  logic [W-1:0]     bypv_p1_d;

  assign a_s = in_a[W-1];
  assign b_s = in_b[W-1] ^ in_sub;
  assign a_e = in_a[W-2 -: EXP_W];
  assign b_e = in_b[W-2 -: EXP_W];
  assign a_m = in_a[MAN_W-1:0];
  assign b_m = in_b[MAN_W-1:0];
  assign a_z = (a_e == '0);
  assign b_z = (b_e == '0);

  always_comb begin
    swap   = {b_e, b_m} > {a_e, a_m};
    l_s    = swap ? b_s : a_s;
    s_s    = swap ? a_s : b_s;
    l_e    = swap ? b_e : a_e;
    s_e    = swap ? a_e : b_e;
    l_m    = swap ? b_m : a_m;
    s_m    = swap ? a_m : b_m;
    diff   = l_e - s_e;
    s_wide = {1'b1, s_m, {(MAN_W+5){1'b0}}} >> diff;
    if (32'(diff) >= DMAX) ssig_p1_d = {{(ALN_W-1){1'b0}}, 1'b1};
    else ssig_p1_d = {s_wide[2*MAN_W+5 -: MAN_W+3], |s_wide[MAN_W+2:0]};
    lsig_p1_d = {1'b1, l_m, 3'b000};
    sgn_p1_d  = l_s;
    sub_p1_d  = l_s ^ s_s;
    byp_p1_d  = a_z | b_z;
    bypz_p1_d = a_z & b_z;
    // A zero operand passes the other through untouched (B with in_sub applied).
    if (a_z & b_z) bypv_p1_d = '0;
    else if (a_z)  bypv_p1_d = {b_s, b_e, b_m};
    else           bypv_p1_d = in_a;
  end

  logic             vld_p1_q, sgn_p1_q, sub_p1_q, byp_p1_q, bypz_p1_q;
  logic [EXP_W-1:0] exp_p1_q;
  logic [ALN_W-1:0] lsig_p1_q, ssig_p1_q;
  logic [W-1:0]     bypv_p1_q;

  // ---- stage 2: magnitude add or subtract (L >= S, never negative)
  logic [SUM_W-1:0] sum_p2_d;
  assign sum_p2_d = sub_p1_q ? ({1'b0, lsig_p1_q} - {1'b0, ssig_p1_q})
                             : ({1'b0, lsig_p1_q} + {1'b0, ssig_p1_q});

  logic             vld_p2_q, sgn_p2_q, byp_p2_q, bypz_p2_q;
  logic [EXP_W-1:0] exp_p2_q;
  logic [SUM_W-1:0] sum_p2_q;
  logic [W-1:0]     bypv_p2_q;

  // ---- stage 3: normalize, round to nearest even, saturate/flush
  logic [ALN_W-1:0]      n_p3;
  logic [LZ_W-1:0]       lz_p3;
  logic signed [E_W-1:0] e_p3;
  logic [MAN_W+1:0]      rsig_p3;
  logic [MAN_W-1:0]      man_p3;
  logic                  inx_p3;
  logic [W-1:0]          res_p3_d;
  logic [3:0]            flg_p3_d;

  always_comb begin
    n_p3     = '0;
    lz_p3    = '0;
    e_p3     = '0;
    rsig_p3  = '0;
    man_p3   = '0;
    inx_p3   = 1'b0;
    res_p3_d = '0;
    flg_p3_d = '0;
    if (byp_p2_q) begin
      res_p3_d = bypv_p2_q;
      flg_p3_d = {3'b000, bypz_p2_q};
    end else if (sum_p2_q == '0) begin
      flg_p3_d = 4'b0001;
    end else begin
      if (sum_p2_q[SUM_W-1]) begin
        n_p3 = {sum_p2_q[SUM_W-1:2], |sum_p2_q[1:0]};
        e_p3 = E_W'(exp_p2_q) + E_W'(1);
      end else begin
        lz_p3 = lzc(sum_p2_q[ALN_W-1:0]);
        n_p3  = sum_p2_q[ALN_W-1:0] << lz_p3;
        e_p3  = E_W'(exp_p2_q) - E_W'(lz_p3);
      end
      inx_p3  = |n_p3[2:0];
      rsig_p3 = rne(n_p3);
      if (rsig_p3[MAN_W+1]) begin
        e_p3   = e_p3 + E_W'(1);
        man_p3 = rsig_p3[MAN_W:1];
      end else begin
        man_p3 = rsig_p3[MAN_W-1:0];
      end
      if (e_p3 > EMAX) begin
        res_p3_d = sat_max(sgn_p2_q);
        flg_p3_d = 4'b1010;
      end else if (e_p3[E_W-1] || e_p3 == '0) begin
        flg_p3_d = 4'b0111;
      end else begin
        res_p3_d = {sgn_p2_q, e_p3[EXP_W-1:0], man_p3};
        flg_p3_d = {2'b00, inx_p3, 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (!stall) begin
      vld_p1_q    <= in_valid;
      vld_p2_q    <= vld_p1_q;
      out_valid_q <= vld_p2_q;
      if (vld_p2_q) begin
        out_result_q <= res_p3_d;
        out_flags_q  <= flg_p3_d;
      end
    end
  end

  // Datapath registers load only with valid data and need no reset.
  always_ff @(posedge clk) begin
    if (!stall && in_valid) begin
      sgn_p1_q  <= sgn_p1_d;
      sub_p1_q  <= sub_p1_d;
      exp_p1_q  <= l_e;
      lsig_p1_q <= lsig_p1_d;
      ssig_p1_q <= ssig_p1_d;
      byp_p1_q  <= byp_p1_d;
      bypz_p1_q <= bypz_p1_d;
      bypv_p1_q <= bypv_p1_d;
    end
    if (!stall && vld_p1_q) begin
      sgn_p2_q  <= sgn_p1_q;
      exp_p2_q  <= exp_p1_q;
      sum_p2_q  <= sum_p2_d;
      byp_p2_q  <= byp_p1_q;
      bypz_p2_q <= bypz_p1_q;
      bypv_p2_q <= bypv_p1_q;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (4/3/7): vector table, latency, stalls,
// reset flush and enable freeze, with a queue-based in-order scoreboard.
module tb_fp_addsub_pipe;
  logic       clk = 1'b0;
  logic       rst_n, ena, in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_result;
  logic [3:0] out_flags;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(4), .MAN_W(3), .BIAS(7)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] f;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  vec_t tbl[16];
  int   total = 0;
  int   bad   = 0;

  // In-order scoreboard on every output transfer of an enabled tile.
  always @(negedge clk) begin
    if (rst_n && ena && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got=%h/%b required=none", out_result, out_flags);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_result !== mon_e.r || out_flags !== mon_e.f) begin
          bad++;
          $display("FAIL result got=%h flags=%b required=%h flags=%b",
                   out_result, out_flags, mon_e.r, mon_e.f);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  task automatic send(input vec_t v);
    res_t t;
    int   n;
    t.r = v.r;
    t.f = v.f;
    exp_q.push_back(t);
    in_a = v.a; in_b = v.b; in_sub = v.sub; in_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) begin
      total++; bad++;
      $display("FAIL accept_timeout got=no_accept required=accept");
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, cnt;
    logic       snap_v;
    logic [7:0] snap_r;
    logic [3:0] snap_f;

    tbl[0]  = '{8'h38, 8'h38, 1'b0, 8'h40, 4'h0};
    tbl[1]  = '{8'h3C, 8'h3C, 1'b0, 8'h44, 4'h0};
    tbl[2]  = '{8'h38, 8'h38, 1'b1, 8'h00, 4'h1};
    tbl[3]  = '{8'h38, 8'h18, 1'b0, 8'h38, 4'h2};
    tbl[4]  = '{8'h39, 8'h18, 1'b0, 8'h3A, 4'h2};
    tbl[5]  = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 4'hA};
    tbl[6]  = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 4'hA};
    tbl[7]  = '{8'h09, 8'h08, 1'b1, 8'h00, 4'h7};
    tbl[8]  = '{8'h40, 8'h38, 1'b1, 8'h38, 4'h0};
    tbl[9]  = '{8'h38, 8'h18, 1'b1, 8'h37, 4'h0};
    tbl[10] = '{8'h38, 8'hC0, 1'b0, 8'hB8, 4'h0};
    tbl[11] = '{8'h3F, 8'h18, 1'b0, 8'h40, 4'h2};
    tbl[12] = '{8'h00, 8'h3C, 1'b1, 8'hBC, 4'h0};
    tbl[13] = '{8'h45, 8'h00, 1'b0, 8'h45, 4'h0};
    tbl[14] = '{8'h00, 8'h80, 1'b0, 8'h00, 4'h1};
    tbl[15] = '{8'h05, 8'h3C, 1'b0, 8'h3C, 4'h0};

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_sub = 1'b0;
    in_a = 8'h00; in_b = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk); #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_result", int'(out_result), 0);
    chk("reset_out_flags", int'(out_flags), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Latency of a single transaction, counted in edges from the accept.
    begin
      res_t t;
      t.r = 8'h40; t.f = 4'h0;
      exp_q.push_back(t);
      in_a = 8'h38; in_b = 8'h38; in_sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk("accept_ready", int'(in_ready), 1);
      @(posedge clk); #2;
      in_valid = 1'b0;
      for (lat = 1; lat <= 20; lat++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      chk("latency", lat, 3);
      drain();
    end

    for (int i = 0; i < 16; i++) send(tbl[i]);
    drain();

    // Back-to-back stream with out_ready held low for 4 cycles.
    fork
      begin
        send(tbl[0]); send(tbl[1]); send(tbl[8]); send(tbl[4]); send(tbl[9]);
      end
      begin
        repeat (4) @(posedge clk); #2;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_out_valid", int'(out_valid), 1);
          chk("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three results in flight.
    send(tbl[0]); send(tbl[1]); send(tbl[4]);
    chk("valid_before_reset", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_kills_valid", int'(out_valid), 0);
    chk("reset_clears_result", int'(out_result), 0);
    exp_q.delete();
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_stale_after_reset", cnt, 0);
    @(posedge clk); #2;

    // Enable dropped for two cycles mid-stream.
    fork
      begin
        send(tbl[10]); send(tbl[11]); send(tbl[12]); send(tbl[13]); send(tbl[5]);
      end
      begin
        repeat (4) @(posedge clk); #2;
        snap_v = out_valid; snap_r = out_result; snap_f = out_flags;
        ena = 1'b0;
        chk("freeze_has_valid", int'(snap_v), 1);
        repeat (2) begin
          @(negedge clk);
          chk("freeze_valid", int'(out_valid), int'(snap_v));
          chk("freeze_result", int'(out_result), int'(snap_r));
          chk("freeze_flags", int'(out_flags), int'(snap_f));
          chk("freeze_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #2;
        ena = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
